// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Dual-slot fetch PC controller. Generates the slot-0 and slot-1 fetch PCs
//   (slot 1 is always slot 0 + 4) and the fetch/flush qualifiers for the
//   front end.
//
//   State    | meaning
//   ---------+------------------------------------------------------------
//   IDLE (0) | first cycle out of reset, PC held, redirect ignored
//   RUN  (1) | fetching; redirect > halt > stall > advance
//   FLUSH(2) | bubble cycles after a redirect, younger stages squashed
//   HALT (3) | fetch stopped; only redirect or reset leaves
//
// Ports
//   clk          : clock, all state updates on rising edge
//   reset        : synchronous active-high reset
//   stall        : pipeline hazard hold request
//   issue_cnt    : instructions consumed this cycle (3 is treated as 2)
//   redirect     : branch/jump redirect request
//   redirect_pc  : redirect target (bits [1:0] ignored)
//   halt         : stop fetching
//   pc0, pc1     : registered slot-0 / slot-1 fetch PCs
//   pc_en        : combinational, high when the PCs change at the next edge
//   fetch_valid  : fetched pair is valid (state == RUN)
//   flush        : squash younger stages (state == FLUSH)
//   state        : debug view of the FSM state
module pc_fetch_ctrl #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       issue_cnt,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic [WIDTH-1:0] pc0,
    output logic [WIDTH-1:0] pc1,
    output logic             pc_en,
    output logic             fetch_valid,
    output logic             flush,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc0_q, pc0_d;
    logic [WIDTH-1:0] pc1_q, pc1_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             pc_en_c;

    logic [1:0]       issue_eff;
    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] redir_al;

    // issue_cnt of 3 saturates to 2 (the pair width)
    assign issue_eff = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign pc_step   = WIDTH'({issue_eff, 2'b00});
    assign redir_al  = redirect_pc & ~WIDTH'(3);

    always_comb begin
        state_d = state_q;
        pc0_d   = pc0_q;
        fcnt_d  = fcnt_q;
        pc_en_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = halt ? ST_HALT : ST_RUN;
            end

            ST_RUN: begin
                if (redirect) begin
                    pc0_d   = redir_al;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                    pc_en_c = 1'b1;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (!stall && issue_eff != 2'd0) begin
                    pc0_d   = pc0_q + pc_step;
                    pc_en_c = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (redirect) begin
                    pc0_d   = redir_al;
                    fcnt_d  = FLUSH_LOAD;
                    pc_en_c = 1'b1;
                end else if (fcnt_q <= 3'd1) begin
                    // last bubble: counter has reached 1
                    fcnt_d  = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    pc0_d   = redir_al;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                    pc_en_c = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc1_d = pc0_d + WIDTH'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc0_q   <= RESET_PC;
            pc1_q   <= RESET_PC + WIDTH'(4);
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // reset overrides any redirect/advance, so no enable while it is held
    assign pc_en       = pc_en_c & ~reset;
    assign pc0         = pc0_q;
    assign pc1         = pc1_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign flush       = (state_q == ST_FLUSH);
    assign state       = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  issue_cnt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        pc_en;
    logic        fetch_valid;
    logic        flush;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  st;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    pc_fetch_ctrl #(
        .WIDTH(32),
        .RESET_PC(32'h0),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .issue_cnt(issue_cnt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .pc0(pc0),
        .pc1(pc1),
        .pc_en(pc_en),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare registered outputs against the oldest scoreboard entry.
    task automatic pop_check();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".pc0"},   pc0,                 e.pc0);
        check({t, ".pc1"},   pc1,                 e.pc1);
        check({t, ".state"}, {30'd0, state},      {30'd0, e.st});
        check({t, ".fv"},    {31'd0, fetch_valid}, {31'd0, (e.st == S_RUN)});
        check({t, ".flush"}, {31'd0, flush},       {31'd0, (e.st == S_FLUSH)});
    endtask

    // One clock: drive inputs, check combinational pc_en (if chk_en),
    // push post-edge expectation, clock, pop and compare.
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic [1:0] ic, input logic rd, input logic [31:0] rpc,
                        input logic hlt, input logic chk_en, input logic en,
                        input logic [31:0] e_pc0, input logic [31:0] e_pc1,
                        input logic [1:0] e_st);
        exp_t e;
        reset       = rst;
        stall       = stl;
        issue_cnt   = ic;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hlt;
        #1;
        if (chk_en) check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, en});
        e.pc0 = e_pc0;
        e.pc1 = e_pc1;
        e.st  = e_st;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; issue_cnt = 2'd0;
        redirect = 1'b1; redirect_pc = 32'h5550; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset overrides the simultaneous redirect
        reset = 1'b0; redirect = 1'b0;
        #1;
        check("rst.pc0",   pc0,                  32'h0);
        check("rst.pc1",   pc1,                  32'h4);
        check("rst.state", {30'd0, state},       {30'd0, S_IDLE});
        check("rst.fv",    {31'd0, fetch_valid}, 32'd0);
        check("rst.flush", {31'd0, flush},       32'd0);
        check("rst.pc_en", {31'd0, pc_en},       32'd0);

        // IDLE -> RUN, then issue 2 for three cycles
        step("idle",  0, 0, 2'd2, 0, 32'h0, 0, 1, 0, 32'h0,  32'h4,  S_RUN);
        step("adv1",  0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h8,  32'hC,  S_RUN);
        step("adv2",  0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h10, 32'h14, S_RUN);
        step("adv3",  0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h18, 32'h1C, S_RUN);

        // redirect to 0x100; halt and stall ignored in FLUSH
        step("rd100", 0, 0, 2'd2, 1, 32'h100, 0, 1, 1, 32'h100, 32'h104, S_FLUSH);
        step("fl1",   0, 0, 2'd2, 0, 32'h0,   1, 1, 0, 32'h100, 32'h104, S_FLUSH);
        step("fl2",   0, 1, 2'd2, 0, 32'h0,   0, 1, 0, 32'h100, 32'h104, S_RUN);

        // partial issue 1, 0, 3
        step("ic1",   0, 0, 2'd1, 0, 32'h0, 0, 1, 1, 32'h104, 32'h108, S_RUN);
        step("ic0",   0, 0, 2'd0, 0, 32'h0, 0, 1, 0, 32'h104, 32'h108, S_RUN);
        step("ic3",   0, 0, 2'd3, 0, 32'h0, 0, 1, 1, 32'h10C, 32'h110, S_RUN);

        // stall holds, then redirect wins over stall
        step("stall", 0, 1, 2'd2, 0, 32'h0,    0, 1, 0, 32'h10C,  32'h110,  S_RUN);
        step("rdstl", 0, 1, 2'd2, 1, 32'h2003, 0, 1, 1, 32'h2000, 32'h2004, S_FLUSH);
        step("rdf1",  0, 0, 2'd0, 0, 32'h0,    0, 1, 0, 32'h2000, 32'h2004, S_FLUSH);
        step("rdf2",  0, 0, 2'd0, 0, 32'h0,    0, 1, 0, 32'h2000, 32'h2004, S_RUN);

        // back-to-back redirects: 3 flush cycles total
        step("b2b40", 0, 0, 2'd0, 1, 32'h40, 0, 1, 1, 32'h40, 32'h44, S_FLUSH);
        step("b2b80", 0, 0, 2'd0, 1, 32'h80, 0, 1, 1, 32'h80, 32'h84, S_FLUSH);
        step("b2bf1", 0, 0, 2'd0, 0, 32'h0,  0, 1, 0, 32'h80, 32'h84, S_FLUSH);
        step("b2bf2", 0, 0, 2'd0, 0, 32'h0,  0, 1, 0, 32'h80, 32'h84, S_RUN);

        // halt beats stall/advance, then PC held in HALT
        step("halt",  0, 1, 2'd2, 0, 32'h0, 1, 1, 0, 32'h80, 32'h84, S_HALT);
        for (int i = 0; i < 10; i++)
            step("hold", 0, 0, 2'd2, 0, 32'h0, i[0], 1, 0, 32'h80, 32'h84, S_HALT);

        // redirect out of HALT near the top of the address space, then wrap
        step("rdwrap", 0, 0, 2'd2, 1, 32'hFFFF_FFF8, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, S_FLUSH);
        step("wf1",    0, 0, 2'd2, 0, 32'h0, 0, 1, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, S_FLUSH);
        step("wf2",    0, 0, 2'd2, 0, 32'h0, 0, 1, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, S_RUN);
        step("wadv1",  0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h0, 32'h4, S_RUN);
        step("wadv2",  0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h8, 32'hC, S_RUN);

        // pc1 wrap and misaligned target
        step("rdfffe", 0, 0, 2'd0, 1, 32'hFFFF_FFFE, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, S_FLUSH);
        step("xf1",    0, 0, 2'd0, 0, 32'h0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, S_FLUSH);
        step("xf2",    0, 0, 2'd0, 0, 32'h0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, S_RUN);
        step("xadv",   0, 0, 2'd2, 0, 32'h0, 0, 1, 1, 32'h4, 32'h8, S_RUN);

        // reset in the second FLUSH cycle, with a redirect also present
        step("rd300",  0, 0, 2'd0, 1, 32'h300, 0, 1, 1, 32'h300, 32'h304, S_FLUSH);
        step("rf1",    0, 0, 2'd0, 0, 32'h0,   0, 1, 0, 32'h300, 32'h304, S_FLUSH);
        step("rstfl",  1, 0, 2'd2, 1, 32'h500, 0, 0, 0, 32'h0,   32'h4,   S_IDLE);
        step("pstidl", 0, 0, 2'd2, 1, 32'h600, 0, 1, 0, 32'h0,   32'h4,   S_RUN);
        step("pstrun", 0, 0, 2'd1, 0, 32'h0,   0, 1, 1, 32'h4,   32'h8,   S_RUN);

        // reset mid-HALT, then halt from IDLE with redirect ignored
        step("h2",     0, 0, 2'd0, 0, 32'h0, 1, 1, 0, 32'h4, 32'h8, S_HALT);
        step("rsth",   1, 0, 2'd0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4, S_IDLE);
        step("idlhlt", 0, 0, 2'd2, 1, 32'h900, 1, 1, 0, 32'h0, 32'h4, S_HALT);
        step("hrd",    0, 0, 2'd0, 1, 32'h1000, 0, 1, 1, 32'h1000, 32'h1004, S_FLUSH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
